count_display: RTL

- Downstream consumer of the mod-16 up/down counter's 4-bit count.
- Converts the count to two decimal digits (00..15) and time-multiplexes them onto a 2-digit 7-segment display.
- Display value updates only at frame boundaries, so a digit pair is never split between two counts (tear-free).
- Flags counter wrap-around (15->0 or 0->15) by lighting the decimal point for a programmable number of frames.

---
 rtl/count_display_pkg.sv | 43 ++++
 rtl/count_display_if.sv | 20 ++
 rtl/seg_scan_timer.sv | 37 +++
 rtl/count_display.sv | 96 +++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// rtl/count_display_pkg.sv - shared 7-segment codes, digit ids and BCD encoder
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : active-high segment codes, bit order {g,f,e,d,c,b,a}
//   DIGIT_ONES, DIGIT_TENS  : scan select values for each digit position
//   bcd_to_seg()            : 4-bit BCD digit -> active-high segment code
package count_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic DIGIT_ONES = 1'b0;
   localparam logic DIGIT_TENS = 1'b1;

   // Non-decimal inputs map to blank rather than a garbage glyph.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] code;
      code = SEG_BLANK;
      case (bcd)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/count_display_if.sv
// rtl/count_display_if.sv - count input and display drive bundle for count_display
// Signals:
//   count      : 4-bit counter value into the display block
//   seg        : segment drive {g,f,e,d,c,b,a}
//   dp         : decimal point (wrap indicator)
//   an         : digit enables, an[0] ones, an[1] tens
//   frame_tick : one-cycle pulse at each frame end
// Modports: master = display block, slave = counter side / observer.
interface count_display_if;

   logic [3:0] count;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] an;
   logic       frame_tick;

   modport master (input count, output seg, output dp, output an, output frame_tick);
   modport slave  (output count, input seg, input dp, input an, input frame_tick);

endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - digit scan divider producing digit select and frame end
// Ports:
//   clkout    : clock
//   reset     : asynchronous active-low reset
//   sel       : current digit (0 ones, 1 tens), toggles every SCAN_DIV cycles
//   frame_end : high on the last cycle of the tens digit (frame boundary)
module seg_scan_timer #(
   parameter int SCAN_DIV = 4
) (
   input  logic clkout,
   input  logic reset,
   output logic sel,
   output logic frame_end
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div;
   logic             div_last;

   assign div_last  = (div == DIV_LAST);
   assign frame_end = div_last & sel;

   always_ff @(posedge clkout or negedge reset) begin
      if (!reset) begin
         div <= '0;
         sel <= 1'b0;
      end else if (div_last) begin
         div <= '0;
         sel <= ~sel;
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/count_display.sv
// rtl/count_display.sv - tear-free 2-digit 7-segment display of a mod-16 count with wrap flag
// Ports:
//   clkout : clock shared with the counter
//   reset  : asynchronous active-low reset
//   dbus   : count_display_if.master (count in; seg, dp, an, frame_tick out)
// Option macro COUNT_DISPLAY_LEAD_ZERO_BLANK_EN: blank the tens digit when it is zero.
module count_display
   import count_display_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int WRAP_HOLD      = 3,
   parameter int ACTIVE_LOW_SEG = 1,
   parameter int ACTIVE_LOW_AN  = 1
) (
   input  logic                   clkout,
   input  logic                   reset,
   count_display_if.master        dbus
);

   // XOR masks turn the active-high internal form into the pad polarity;
   // the same masks are the "unlit / disabled" values.
   localparam logic [6:0] SEG_OFF   = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF    = (ACTIVE_LOW_SEG != 0);
   localparam logic [1:0] AN_OFF    = (ACTIVE_LOW_AN != 0) ? 2'b11 : 2'b00;
   localparam logic [3:0] HOLD_LOAD = 4'(WRAP_HOLD);

   logic [3:0] cnt_q;
   logic [3:0] disp_q;
   logic [3:0] wrap_cnt;
   logic       primed;
   logic       sel;
   logic       frame_end;
   logic       wrap;

   logic       tens;
   logic [3:0] ones;
   logic [6:0] seg_hi;
   logic [1:0] an_hi;

   seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clkout    (clkout),
      .reset     (reset),
      .sel       (sel),
      .frame_end (frame_end)
   );

   // primed masks the reset value of cnt_q, which would otherwise fake a 0->15 wrap.
   assign wrap = primed & (((cnt_q == 4'd15) && (dbus.count == 4'd0)) ||
                           ((cnt_q == 4'd0)  && (dbus.count == 4'd15)));

   always_comb begin
      tens   = (disp_q >= 4'd10);
      ones   = tens ? (disp_q - 4'd10) : disp_q;
      seg_hi = bcd_to_seg(ones);
      an_hi  = 2'b01;
      if (sel == DIGIT_TENS) begin
         an_hi  = 2'b10;
`ifdef COUNT_DISPLAY_LEAD_ZERO_BLANK_EN
         seg_hi = tens ? SEG_1 : SEG_BLANK;
`else
         seg_hi = bcd_to_seg({3'b000, tens});
`endif
      end
   end

   always_ff @(posedge clkout or negedge reset) begin
      if (!reset) begin
         cnt_q           <= 4'd0;
         disp_q          <= 4'd0;
         wrap_cnt        <= 4'd0;
         primed          <= 1'b0;
         dbus.seg        <= SEG_OFF;
         dbus.dp         <= DP_OFF;
         dbus.an         <= AN_OFF;
         dbus.frame_tick <= 1'b0;
      end else begin
         cnt_q           <= dbus.count;
         primed          <= 1'b1;
         dbus.frame_tick <= frame_end;
         // disp_q only moves when sel returns to the ones digit, so both
         // digits of one frame always come from the same sample.
         if (frame_end) begin
            disp_q <= cnt_q;
         end
         if (wrap) begin
            wrap_cnt <= HOLD_LOAD;
         end else if (frame_end && (wrap_cnt != 4'd0)) begin
            wrap_cnt <= wrap_cnt - 4'd1;
         end
         dbus.seg <= seg_hi ^ SEG_OFF;
         dbus.an  <= an_hi ^ AN_OFF;
         dbus.dp  <= (wrap_cnt != 4'd0) ^ DP_OFF;
      end
   end

endmodule
